// File: rtl/seg_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : seg_bcd_display
// Brief    : Iterative double-dabble binary-to-BCD converter driving active-low
//            seven-segment digits, with start/busy/done handshake, leading-zero
//            blanking and overflow dash display.
// Revision : 1.0 - initial release
// ============================================================================
module seg_bcd_display #(
    parameter int IN_WIDTH      = 8,
    parameter int DIGITS        = 3,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   value,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(IN_WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_LOAD  = 2'd2;

    localparam logic [6:0] c_SEG_BLANK = 7'h7F;
    localparam logic [6:0] c_SEG_DASH  = 7'h3F;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [IN_WIDTH-1:0]  r_shift;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_BCD_W-1:0]   w_adj;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ovf_sticky;
    logic                 r_done;
    logic                 r_overflow;
    logic [7*DIGITS-1:0]  r_hex;
    logic [7*DIGITS-1:0]  w_hex_next;
    logic                 w_hi_zero;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_next = c_SHIFT;
            c_SHIFT: if (r_cnt == c_LAST) w_state_next = c_LOAD;
            c_LOAD:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Add-3 correction is applied to every nibble from its pre-shift value
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_adj
            assign w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ?
                                     (r_bcd[4*k +: 4] + 4'd3) : r_bcd[4*k +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift      <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_hex        <= '1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_shift      <= value;
                        r_bcd        <= '0;
                        r_cnt        <= '0;
                        r_ovf_sticky <= 1'b0;
                    end
                end
                c_SHIFT: begin
                    r_bcd        <= {w_adj[c_BCD_W-2:0], r_shift[IN_WIDTH-1]};
                    r_shift      <= r_shift << 1;
                    r_ovf_sticky <= r_ovf_sticky | w_adj[c_BCD_W-1];
                    r_cnt        <= r_cnt + c_CNT_W'(1);
                end
                c_LOAD: begin
                    r_hex      <= w_hex_next;
                    r_overflow <= r_ovf_sticky;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Walk from the most significant digit down so blanking stops at the first non-zero
    always_comb begin
        w_hex_next = '1;
        w_hi_zero  = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_hi_zero = w_hi_zero & (r_bcd[4*k +: 4] == 4'd0);
            if (r_ovf_sticky) begin
                w_hex_next[7*k +: 7] = c_SEG_DASH;
            end else if ((BLANK_LEADING != 0) && (k != 0) && w_hi_zero) begin
                w_hex_next[7*k +: 7] = c_SEG_BLANK;
            end else begin
                w_hex_next[7*k +: 7] = seg7(r_bcd[4*k +: 4]);
            end
        end
    end

    assign busy     = (r_state != c_IDLE);
    assign done     = r_done;
    assign overflow = r_overflow;
    assign hex      = r_hex;

endmodule
`default_nettype wire
